// File: rtl/line_clear_if.sv
// Board-side and game-side signals of the line-clear sequencer.
// master: the sequencer; slave: the game FSM plus board model it talks to.
interface line_clear_if #(
    parameter int XW = 4,
    parameter int YW = 5
);
    logic          start;
    logic          busy;
    logic          done;
    logic [4:0]    lines_cleared;
    logic [XW-1:0] rx;
    logic [YW-1:0] ry;
    logic          rdata;
    logic          we;
    logic [XW-1:0] wx;
    logic [YW-1:0] wy;
    logic          wdata;

    modport master (
        input  start, rdata,
        output busy, done, lines_cleared, rx, ry, we, wx, wy, wdata
    );

    modport slave (
        output start, rdata,
        input  busy, done, lines_cleared, rx, ry, we, wx, wy, wdata
    );
endinterface

// File: rtl/line_clear_ctrl.sv
// Row-clear sequencer: scans rows bottom-up, drops everything above a full row by one,
// then blanks row 0 and re-tests the same row. One board cell is touched per cycle.
module line_clear_ctrl #(
    parameter int COLS = 10,
    parameter int ROWS = 20,
    parameter int XW   = 4,
    parameter int YW   = 5
) (
    input  logic          CLOCK_50,
    input  logic          reset,
    line_clear_if.master  bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_SHIFT = 3'd2,
        S_CLEAR = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [XW-1:0] X_LAST = XW'(COLS - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    state_t        state_q, state_d;
    logic [YW-1:0] cy_q, cy_d, sy_q, sy_d;
    logic [XW-1:0] cx_q, cx_d, sx_q, sx_d;
    logic [4:0]    count_q, count_d;

    logic          busy_q, done_q, we_q;
    logic [4:0]    lines_q;
    logic [XW-1:0] rx_q, wx_q;
    logic [YW-1:0] ry_q, wy_q;

    // Next-state and cursor update for the scan / shift / clear sequence.
    always_comb begin
        state_d = state_q;
        cy_d    = cy_q;
        cx_d    = cx_q;
        sy_d    = sy_q;
        sx_d    = sx_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_CHECK;
                    cy_d    = Y_LAST;
                    cx_d    = {XW{1'b0}};
                    count_d = 5'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CHECK: begin
                if (!bus.rdata) begin
                    if (cy_q == {YW{1'b0}}) begin
                        state_d = S_DONE;
                    end else begin
                        cy_d = cy_q - YW'(1);
                        cx_d = {XW{1'b0}};
                    end
                end else if (cx_q != X_LAST) begin
                    cx_d = cx_q + XW'(1);
                end else begin
                    count_d = count_q + 5'd1;
                    sx_d    = {XW{1'b0}};
                    if (cy_q == {YW{1'b0}}) begin
                        state_d = S_CLEAR;
                    end else begin
                        state_d = S_SHIFT;
                        sy_d    = cy_q;
                    end
                end
            end
            S_SHIFT: begin
                if (sx_q != X_LAST) begin
                    sx_d = sx_q + XW'(1);
                end else begin
                    sx_d = {XW{1'b0}};
                    if (sy_q == YW'(1)) begin
                        state_d = S_CLEAR;
                    end else begin
                        sy_d = sy_q - YW'(1);
                    end
                end
            end
            S_CLEAR: begin
                if (sx_q != X_LAST) begin
                    sx_d = sx_q + XW'(1);
                end else begin
                    sx_d    = {XW{1'b0}};
                    cx_d    = {XW{1'b0}};
                    state_d = S_CHECK;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, counters and outputs; outputs are decoded from the next state so they line up with it.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cy_q    <= {YW{1'b0}};
            cx_q    <= {XW{1'b0}};
            sy_q    <= {YW{1'b0}};
            sx_q    <= {XW{1'b0}};
            count_q <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            we_q    <= 1'b0;
            lines_q <= 5'd0;
            rx_q    <= {XW{1'b0}};
            ry_q    <= {YW{1'b0}};
            wx_q    <= {XW{1'b0}};
            wy_q    <= {YW{1'b0}};
        end else begin
            state_q <= state_d;
            cy_q    <= cy_d;
            cx_q    <= cx_d;
            sy_q    <= sy_d;
            sx_q    <= sx_d;
            count_q <= count_d;
            busy_q  <= (state_d == S_CHECK) || (state_d == S_SHIFT) || (state_d == S_CLEAR);
            done_q  <= (state_d == S_DONE);
            we_q    <= (state_d == S_SHIFT) || (state_d == S_CLEAR);
            wx_q    <= sx_d;
            wy_q    <= (state_d == S_SHIFT) ? sy_d : {YW{1'b0}};
            if (state_d == S_DONE) begin
                lines_q <= count_d;
            end else begin
                lines_q <= lines_q;
            end
            case (state_d)
                S_CHECK: begin
                    rx_q <= cx_d;
                    ry_q <= cy_d;
                end
                S_SHIFT: begin
                    rx_q <= sx_d;
                    ry_q <= sy_d - YW'(1);
                end
                default: begin
                    rx_q <= {XW{1'b0}};
                    ry_q <= {YW{1'b0}};
                end
            endcase
        end
    end

    // The cell read from the row above is written in the same cycle, so wdata follows rdata.
    always_comb begin
        if (state_q == S_SHIFT) begin
            bus.wdata = bus.rdata;
        end else begin
            bus.wdata = 1'b0;
        end
    end

    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.we            = we_q;
    assign bus.lines_cleared = lines_q;
    assign bus.rx            = rx_q;
    assign bus.ry            = ry_q;
    assign bus.wx            = wx_q;
    assign bus.wy            = wy_q;
endmodule

// File: tb/tb_line_clear_ctrl.sv
// Bench for line_clear_ctrl: board model plus row-level reference of the clear pass.
module tb_line_clear_ctrl;
    localparam int COLS = 10;
    localparam int ROWS = 20;
    localparam int BUDGET = 6000;

    logic CLOCK_50 = 1'b0;
    logic reset;
    always #5 CLOCK_50 = ~CLOCK_50;

    line_clear_if #(.XW(4), .YW(5)) bus ();

    line_clear_ctrl #(.COLS(COLS), .ROWS(ROWS), .XW(4), .YW(5)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .bus      (bus)
    );

    logic [COLS-1:0] board      [ROWS];
    logic [COLS-1:0] init_board [ROWS];
    logic [COLS-1:0] exp_board  [ROWS];
    logic            load_req = 1'b0;
    int              bad_writes = 0;
    int              exp_lines, exp_cycles, exp_writes;
    int              n_cmp = 0;
    int              n_bad = 0;

    // Board memory: bulk load from the bench, otherwise one write per cycle from the DUT.
    always @(posedge CLOCK_50) begin
        if (load_req) begin
            for (int r = 0; r < ROWS; r++) board[r] <= init_board[r];
        end else if (bus.we === 1'b1) begin
            if (int'(bus.wx) < COLS && int'(bus.wy) < ROWS) board[bus.wy][bus.wx] <= bus.wdata;
            else bad_writes++;
        end
    end

    assign bus.rdata = (int'(bus.rx) < COLS && int'(bus.ry) < ROWS) ? board[bus.ry][bus.rx] : 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: work row by row on a copy of the board using the pass rules.
    task automatic model_pass();
        logic [COLS-1:0] rows [ROWS];
        int y, fz;
        for (int r = 0; r < ROWS; r++) rows[r] = init_board[r];
        exp_lines = 0; exp_cycles = 0; exp_writes = 0;
        y = ROWS - 1;
        while (1) begin
            if (rows[y] == {COLS{1'b1}}) begin
                exp_lines++;
                exp_cycles += COLS + y * COLS + COLS;
                exp_writes += y * COLS + COLS;
                for (int r = y; r > 0; r--) rows[r] = rows[r-1];
                rows[0] = '0;
            end else begin
                fz = COLS;
                for (int x = COLS - 1; x >= 0; x--) if (!rows[y][x]) fz = x;
                exp_cycles += fz + 1;
                if (y == 0) break;
                y--;
            end
        end
        for (int r = 0; r < ROWS; r++) exp_board[r] = rows[r];
    endtask

    task automatic load_board();
        @(negedge CLOCK_50);
        load_req = 1'b1;
        @(negedge CLOCK_50);
        load_req = 1'b0;
    endtask

    task automatic clear_init();
        for (int r = 0; r < ROWS; r++) init_board[r] = '0;
    endtask

    task automatic run_pass(input string name, input int repulse_at);
        int busy_cyc = 0, done_cnt = 0, we_seen = 0, cyc = 0, row_diff = 0;
        bit fin = 1'b0;
        bad_writes = 0;
        load_board();
        model_pass();
        @(negedge CLOCK_50);
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        bus.start = 1'b0;
        while (!fin && cyc < BUDGET) begin
            if (bus.busy === 1'b1) busy_cyc++;
            if (bus.we === 1'b1) we_seen++;
            if (bus.done === 1'b1) begin
                done_cnt++;
                fin = 1'b1;
                chk({name, ".lines"}, 32'(bus.lines_cleared), 32'(exp_lines));
            end
            bus.start = (repulse_at >= 0 && cyc == repulse_at);
            cyc++;
            @(negedge CLOCK_50);
        end
        bus.start = 1'b0;
        chk({name, ".finished"}, 32'(fin), 32'd1);
        chk({name, ".done_1cyc"}, 32'(bus.done), 32'd0);
        chk({name, ".idle_busy"}, 32'(bus.busy), 32'd0);
        chk({name, ".lines_hold"}, 32'(bus.lines_cleared), 32'(exp_lines));
        for (int i = 0; i < 3; i++) begin
            if (bus.done === 1'b1) done_cnt++;
            @(negedge CLOCK_50);
        end
        chk({name, ".done_count"}, 32'(done_cnt), 32'd1);
        chk({name, ".busy_cycles"}, 32'(busy_cyc), 32'(exp_cycles));
        chk({name, ".writes"}, 32'(we_seen), 32'(exp_writes));
        chk({name, ".bad_writes"}, 32'(bad_writes), 32'd0);
        for (int r = 0; r < ROWS; r++) if (board[r] !== exp_board[r]) row_diff++;
        chk({name, ".board_rows_diff"}, 32'(row_diff), 32'd0);
    endtask

    initial begin
        int waited;
        bit saw_we;
        reset = 1'b1;
        bus.start = 1'b0;
        clear_init();
        repeat (2) @(negedge CLOCK_50);
        chk("rst.busy", 32'(bus.busy), 32'd0);
        chk("rst.done", 32'(bus.done), 32'd0);
        chk("rst.we", 32'(bus.we), 32'd0);
        chk("rst.lines", 32'(bus.lines_cleared), 32'd0);
        chk("rst.rxry", {bus.rx, bus.ry}, 32'd0);
        reset = 1'b0;

        clear_init();
        run_pass("empty", -1);

        clear_init();
        init_board[19] = '1;
        run_pass("row19", -1);

        clear_init();
        init_board[18] = '1;
        init_board[19] = '1;
        init_board[17][3] = 1'b1;
        run_pass("rows18_19", -1);

        clear_init();
        init_board[0] = '1;
        run_pass("row0", -1);

        clear_init();
        init_board[19] = '1;
        run_pass("repulse", 50);

        // Abort in the middle of the shift and confirm reset acts without a clock edge.
        clear_init();
        init_board[19] = '1;
        load_board();
        @(negedge CLOCK_50);
        bus.start = 1'b1;
        @(negedge CLOCK_50);
        bus.start = 1'b0;
        saw_we = 1'b0;
        waited = 0;
        while (waited < 100 && !saw_we) begin
            @(negedge CLOCK_50);
            if (bus.we === 1'b1 && waited > 20) saw_we = 1'b1;
            waited++;
        end
        chk("midrst.in_shift", 32'(saw_we), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("midrst.busy", 32'(bus.busy), 32'd0);
        chk("midrst.we", 32'(bus.we), 32'd0);
        @(negedge CLOCK_50);
        reset = 1'b0;
        clear_init();
        init_board[19] = '1;
        run_pass("after_rst", -1);

        for (int t = 0; t < 8; t++) begin
            for (int r = 0; r < ROWS; r++) begin
                if ($urandom_range(0, 2) == 0) init_board[r] = '1;
                else init_board[r] = COLS'($urandom);
            end
            run_pass($sformatf("rand%0d", t), (t % 2 == 0) ? int'($urandom_range(0, 100)) : -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
